// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared types and constants for serial_tx_shifter
//
// Purpose: holds the default word width, the transmitter state encoding and
// the bit-counter width helper. The PARITY state is present only when the
// PARITY_EN macro is defined.
// Ports: none (package).
package serial_tx_pkg;

  localparam int NBITS_DATA_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } tx_state_t;

  // The counter must be able to represent NBITS_DATA itself, because it
  // increments once more on the edge that completes the last bit.
  function automatic int cnt_width(input int nbits);
    return $clog2(nbits + 1);
  endfunction

endpackage

// File: rtl/serial_tx_shifter_if.sv
// rtl/serial_tx_shifter_if.sv - load handshake and serial link bundle
//
// Purpose: groups the parallel load handshake and the serial output strobe
// towards the receiving shift register. parity_bit exists only when the
// PARITY_EN macro is defined.
// Ports (signals):
//   Din        parallel word, sampled on an accepted load
//   load       request to send Din
//   ready      transmitter can accept a word
//   Dout_serie serial bit, valid while SEL=1
//   SEL        shift strobe for the receiver
//   done       one-cycle pulse after a frame
//   parity_bit even parity of the frame (PARITY_EN only)
// Modports: master drives Din/load, slave is the transmitter.
interface serial_tx_shifter_if
  import serial_tx_pkg::*;
#(
  parameter int NBITS_DATA = NBITS_DATA_DEFAULT
) ();

  logic [NBITS_DATA-1:0] Din;
  logic                  load;
  logic                  ready;
  logic                  Dout_serie;
  logic                  SEL;
  logic                  done;
`ifdef PARITY_EN
  logic                  parity_bit;
`endif

  modport master (
    output Din, load,
    input  ready, Dout_serie, SEL, done
`ifdef PARITY_EN
    , parity_bit
`endif
  );

  modport slave (
    input  Din, load,
    output ready, Dout_serie, SEL, done
`ifdef PARITY_EN
    , parity_bit
`endif
  );

endinterface

// File: rtl/tx_bit_counter.sv
// rtl/tx_bit_counter.sv - clearable enabled up-counter with terminal flag
//
// Purpose: counts transmitted bits; tc is high while the count equals
// NBITS_DATA-1, i.e. during the cycle that carries the last bit.
// Ports:
//   clk   rising-edge clock
//   reset asynchronous active-low reset
//   clr   synchronous clear (has priority over en)
//   en    count enable
//   tc    terminal-count flag
module tx_bit_counter
  import serial_tx_pkg::*;
#(
  parameter int NBITS_DATA = NBITS_DATA_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_width(NBITS_DATA);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(NBITS_DATA - 1));

endmodule

// File: rtl/serial_tx_shifter.sv
// rtl/serial_tx_shifter.sv - parallel-to-serial transmitter, LSB first
//
// Purpose: accepts a word on load && ready and shifts it out one bit per
// clock with SEL high, then pulses done. With the PARITY_EN macro defined a
// trailing cycle with SEL=0 presents the even parity of the word.
// Ports:
//   clk   rising-edge clock
//   reset asynchronous active-low reset
//   bus   serial_tx_shifter_if.slave (Din, load, ready, Dout_serie, SEL,
//         done, parity_bit with PARITY_EN)
module serial_tx_shifter
  import serial_tx_pkg::*;
#(
  parameter int NBITS_DATA = NBITS_DATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_tx_shifter_if.slave   bus
);

  tx_state_t             state_q, state_d;
  logic [NBITS_DATA-1:0] shreg;
  logic                  done_q, done_d;
  logic                  cnt_clr, cnt_en, cnt_tc;
  logic                  accept;
`ifdef PARITY_EN
  logic                  par_q;
`endif

  // Only IDLE accepts a word, so Din changes mid-frame never reach shreg.
  assign accept = bus.load && (state_q == IDLE);

  tx_bit_counter #(
    .NBITS_DATA (NBITS_DATA)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
`ifdef PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= bus.Din;
    end else if (state_q == SHIFT) begin
      shreg <= {1'b0, shreg[NBITS_DATA-1:1]};
    end
  end

`ifdef PARITY_EN
  // Parity is taken from the captured word so it is immune to later Din.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^bus.Din;
    end
  end

  assign bus.parity_bit = (state_q == PARITY) && par_q;
`endif

  assign bus.ready      = (state_q == IDLE);
  assign bus.SEL        = (state_q == SHIFT);
  assign bus.Dout_serie = (state_q == SHIFT) && shreg[0];
  assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// tb/tb_serial_tx_shifter.sv - directed bench for serial_tx_shifter
module tb_serial_tx_shifter;
  import serial_tx_pkg::*;

  localparam int N = 4;
`ifdef PARITY_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  serial_tx_shifter_if #(.NBITS_DATA(N)) bus ();

  serial_tx_shifter #(.NBITS_DATA(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Loopback receiver: shifts right, serial data enters the MSB.
  logic [N-1:0] rx;
  always @(posedge clk) begin
    if (bus.SEL) rx <= {bus.Dout_serie, rx[N-1:1]};
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [N-1:0] w, input logic exp_par, input string tag);
    bus.Din  = w;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s sel%0d", tag, i), 32'(bus.SEL), 32'd1);
      check($sformatf("%s bit%0d", tag, i), 32'(bus.Dout_serie), 32'(w[i]));
      check($sformatf("%s busy%0d", tag, i), 32'(bus.ready), 32'd0);
      check($sformatf("%s nodone%0d", tag, i), 32'(bus.done), 32'd0);
      tick();
    end
`ifdef PARITY_EN
    check({tag, " par_sel"}, 32'(bus.SEL), 32'd0);
    check({tag, " par_bit"}, 32'(bus.parity_bit), 32'(exp_par));
    check({tag, " par_busy"}, 32'(bus.ready), 32'd0);
    tick();
`endif
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " done_ready"}, 32'(bus.ready), 32'd1);
    check({tag, " done_sel"}, 32'(bus.SEL), 32'd0);
    check({tag, " rx"}, 32'(rx), 32'(w));
    tick();
    check({tag, " done_clr"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [N-1:0] pat;
    logic [7:0]   ser;
    int           nsel;
    int           ndone;
    logic         reloaded;

    bus.Din  = '0;
    bus.load = 1'b0;
    #2 reset = 1'b0;
    tick();
    tick();
    check("rst ready", 32'(bus.ready), 32'd1);
    check("rst sel", 32'(bus.SEL), 32'd0);
    check("rst dout", 32'(bus.Dout_serie), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    reset = 1'b1;

    // Idle after reset release, no load.
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("idle%0d", c), {28'd0, bus.ready, bus.SEL, bus.Dout_serie, bus.done}, 32'h8);
    end

    // Basic frame 1011 -> 1,1,0,1; even parity 1.
    run_frame(4'b1011, 1'b1, "f1011");

    // Din changed and load held high mid-frame.
    pat      = 4'b0110;
    bus.Din  = pat;
    bus.load = 1'b1;
    tick();
    bus.Din  = 4'b0000;
    for (int i = 0; i < N; i++) begin
      check($sformatf("hold sel%0d", i), 32'(bus.SEL), 32'd1);
      check($sformatf("hold bit%0d", i), 32'(bus.Dout_serie), 32'(pat[i]));
      check($sformatf("hold busy%0d", i), 32'(bus.ready), 32'd0);
      tick();
    end
`ifdef PARITY_EN
    check("hold par_bit", 32'(bus.parity_bit), 32'd0);
    check("hold par_busy", 32'(bus.ready), 32'd0);
    tick();
`endif
    check("hold done", 32'(bus.done), 32'd1);
    check("hold rx", 32'(rx), 32'h6);
    bus.load = 1'b0;
    tick();
    check("hold no_extra_sel", 32'(bus.SEL), 32'd0);
    check("hold idle_ready", 32'(bus.ready), 32'd1);

    // Back-to-back 1001 then 0111, reload in the done cycle.
    bus.Din  = 4'b1001;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    ser      = '0;
    nsel     = 0;
    ndone    = 0;
    reloaded = 1'b0;
    for (int c = 0; c < 2 * FL + 4; c++) begin
      if (bus.SEL) begin
        if (nsel < 8) ser[nsel] = bus.Dout_serie;
        nsel++;
      end
      if (bus.done) ndone++;
      if (bus.done && !reloaded) begin
        bus.Din  = 4'b0111;
        bus.load = 1'b1;
        reloaded = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      tick();
    end
    check("b2b nsel", 32'(nsel), 32'd8);
    check("b2b serial", 32'(ser), 32'h79);
    check("b2b ndone", 32'(ndone), 32'd2);
    check("b2b rx", 32'(rx), 32'h7);

    // Reset mid-frame after the second bit of 1111.
    bus.Din  = 4'b1111;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("abort sel", 32'(bus.SEL), 32'd0);
    check("abort ready", 32'(bus.ready), 32'd1);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort dout", 32'(bus.Dout_serie), 32'd0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("abort nodone%0d", c), 32'(bus.done), 32'd0);
      check($sformatf("abort nosel%0d", c), 32'(bus.SEL), 32'd0);
    end
    run_frame(4'b0001, 1'b1, "f0001");

    // Parity-zero word.
    run_frame(4'b0110, 1'b0, "f0110");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
